// File: rtl/controle_linhas_bloq_pkg.sv
// Shared definitions for the block-row controller: FSM encoding,
// board limits and default timing parameters.
package controle_linhas_bloq_pkg;

   typedef enum logic [1:0] {
      OCIOSO    = 2'd0,
      PEDIDO    = 2'd1,
      INTERVALO = 2'd2,
      ERRO      = 2'd3
   } estado_t;

   localparam int MAX_LINHAS       = 7;
   localparam int LARGURA_LINHAS   = 3;
   localparam int LARGURA_CONTADOR = 8;
   localparam int INTERVALO_PADRAO = 8;
   localparam int TIMEOUT_PADRAO   = 255;

endpackage

// File: rtl/controle_linhas_bloq_if.sv
// Handshake bus between the row controller (master) and the board writer (slave).
interface controle_linhas_bloq_if;
   import controle_linhas_bloq_pkg::*;

   logic                      req;
   logic                      op;
   logic [LARGURA_LINHAS-1:0] linha_idx;
   logic                      ack;

   modport master (output req, output op, output linha_idx, input ack);
   modport slave  (input req, input op, input linha_idx, output ack);

endinterface

// File: rtl/controle_linhas_bloq_contador_intervalo.sv
// 8-bit loadable counter with count enable and zero flag. The counting
// direction is fixed per instance: down for cooldown, up for timeout.
module contador_intervalo #(
   parameter bit CRESCENTE = 1'b0
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       carrega,
   input  logic       habilita,
   input  logic [7:0] valor_carga,
   output logic [7:0] valor,
   output logic       zero
);

   // Load has priority over counting; counting only happens when enabled.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valor <= 8'd0;
      end else if (carrega) begin
         valor <= valor_carga;
      end else if (habilita) begin
         valor <= CRESCENTE ? valor + 8'd1 : valor - 8'd1;
      end
   end

   assign zero = (valor == 8'd0);

endmodule

// File: rtl/controle_linhas_bloq.sv
// Block-row controller: walks the number of rows on the board towards the
// target one row at a time, with a req/ack handshake per row, an enforced
// cooldown between operations and a timeout on a missing ack.
module controle_linhas_bloq #(
   parameter int INTERVALO = controle_linhas_bloq_pkg::INTERVALO_PADRAO,
   parameter int TIMEOUT   = controle_linhas_bloq_pkg::TIMEOUT_PADRAO
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  pausa,
   input  logic [2:0]            linhas_alvo,
   controle_linhas_bloq_if.master barramento,
   output logic [2:0]            linhas_aplicadas,
   output logic                  ocupado,
   output logic                  erro_timeout
);
   import controle_linhas_bloq_pkg::*;

   localparam logic [7:0] CARGA_INTERVALO = 8'(INTERVALO - 1);
   localparam logic [7:0] FIM_TIMEOUT     = 8'(TIMEOUT - 1);

   estado_t    estado;
   estado_t    proximo;
   logic       op_q;
   logic [2:0] idx_q;
   logic [2:0] aplicadas_q;
   logic       insere;
   logic       inicia;
   logic       conclui;
   logic       carrega_intervalo;
   logic       habilita_intervalo;
   logic       carrega_timeout;
   logic       habilita_timeout;
   logic [7:0] valor_intervalo;
   logic       zero_intervalo;
   logic [7:0] valor_timeout;
   logic       zero_timeout;
   logic       contadores_unused;

   assign insere = (linhas_alvo > aplicadas_q);

   // State register; reset forces the idle state immediately.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado <= OCIOSO;
      end else begin
         estado <= proximo;
      end
   end

   // Next-state and counter control. An ack always wins over an expiring timeout.
   always_comb begin
      proximo            = estado;
      inicia             = 1'b0;
      conclui            = 1'b0;
      carrega_intervalo  = 1'b0;
      habilita_intervalo = 1'b0;
      carrega_timeout    = 1'b0;
      habilita_timeout   = 1'b0;
      case (estado)
         OCIOSO: begin
            if (enable && !pausa && (linhas_alvo != aplicadas_q)) begin
               proximo         = PEDIDO;
               inicia          = 1'b1;
               carrega_timeout = 1'b1;
            end
         end
         PEDIDO: begin
            if (barramento.ack) begin
               proximo           = controle_linhas_bloq_pkg::INTERVALO;
               conclui           = 1'b1;
               carrega_intervalo = 1'b1;
            end else if (valor_timeout == FIM_TIMEOUT) begin
               proximo = ERRO;
            end else begin
               habilita_timeout = 1'b1;
            end
         end
         controle_linhas_bloq_pkg::INTERVALO: begin
            if (zero_intervalo) begin
               proximo = OCIOSO;
            end else if (!pausa) begin
               habilita_intervalo = 1'b1;
            end
         end
         ERRO: begin
            if (!enable) begin
               proximo = OCIOSO;
            end
         end
         default: proximo = OCIOSO;
      endcase
   end

   // Latch the operation when a request starts and apply it when acknowledged.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         op_q        <= 1'b0;
         idx_q       <= 3'd0;
         aplicadas_q <= 3'd0;
      end else begin
         if (inicia) begin
            op_q  <= insere;
            idx_q <= insere ? aplicadas_q : aplicadas_q - 3'd1;
         end
         if (conclui) begin
            aplicadas_q <= op_q ? aplicadas_q + 3'd1 : aplicadas_q - 3'd1;
         end
      end
   end

   contador_intervalo #(.CRESCENTE(1'b0)) u_cooldown (
      .clock       (clock),
      .reset_n     (reset_n),
      .carrega     (carrega_intervalo),
      .habilita    (habilita_intervalo),
      .valor_carga (CARGA_INTERVALO),
      .valor       (valor_intervalo),
      .zero        (zero_intervalo)
   );

   contador_intervalo #(.CRESCENTE(1'b1)) u_timeout (
      .clock       (clock),
      .reset_n     (reset_n),
      .carrega     (carrega_timeout),
      .habilita    (habilita_timeout),
      .valor_carga (8'd0),
      .valor       (valor_timeout),
      .zero        (zero_timeout)
   );

   assign contadores_unused = ^{valor_intervalo, zero_timeout};

   assign barramento.req       = (estado == PEDIDO);
   assign barramento.op        = op_q;
   assign barramento.linha_idx = idx_q;
   assign linhas_aplicadas     = aplicadas_q;
   assign ocupado              = (estado != OCIOSO);
   assign erro_timeout         = (estado == ERRO);

endmodule
